// File: rtl/tick_led_sequencer.sv
// rtl/tick_led_sequencer.sv - tick-driven LED pattern engine (COUNT/WALK/BOUNCE/BLINK)
// Optional build macro SEQ_DUAL_EDGE_EN: advance on both tick_in edges instead of rising only.
module tick_led_sequencer #(
    parameter int LED_COUNT   = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 tick_in,
    input  logic                 en,
    input  logic [1:0]           mode,
    output logic [LED_COUNT-1:0] leds,
    output logic                 step,
    output logic                 wrap
);

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    localparam logic [LED_COUNT-1:0] LEDS_ONES = {LED_COUNT{1'b1}};
    localparam logic [LED_COUNT-1:0] LEDS_ZERO = {LED_COUNT{1'b0}};
    localparam logic [LED_COUNT-1:0] LEDS_LSB  = {{(LED_COUNT-1){1'b0}}, 1'b1};
    localparam logic [LED_COUNT-1:0] LEDS_INC  = LEDS_LSB;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tick_s;
    logic                   tick_d;
    logic                   adv;
    mode_t                  mode_q;
    logic                   dir_down;

    logic [LED_COUNT-1:0]   nxt_leds;
    logic                   nxt_wrap;
    logic                   nxt_dir_down;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
            tick_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
            tick_d <= tick_s;
        end
    end

    assign tick_s = sync_q[SYNC_STAGES-1];

`ifdef SEQ_DUAL_EDGE_EN
    assign adv = (tick_s ^ tick_d) & en;
`else
    assign adv = tick_s & ~tick_d & en;
`endif

    function automatic logic [LED_COUNT-1:0] start_of(input mode_t m);
        case (m)
            MODE_WALK, MODE_BOUNCE: start_of = LEDS_LSB;
            default:                start_of = LEDS_ZERO;
        endcase
    endfunction

    // Next pattern for the current mode; an unrecognised mode_q restarts without wrap.
    always_comb begin
        nxt_leds     = leds;
        nxt_wrap     = 1'b0;
        nxt_dir_down = dir_down;
        case (mode_q)
            MODE_COUNT: begin
                nxt_leds = leds + LEDS_INC;
                nxt_wrap = &leds;
            end
            MODE_WALK: begin
                nxt_leds = {leds[LED_COUNT-2:0], leds[LED_COUNT-1]};
                nxt_wrap = nxt_leds[0];
            end
            MODE_BOUNCE: begin
                if (!dir_down) begin
                    nxt_leds = leds << 1;
                    if (nxt_leds[LED_COUNT-1]) begin
                        nxt_dir_down = 1'b1;
                    end
                end else begin
                    nxt_leds = leds >> 1;
                    if (nxt_leds[0]) begin
                        nxt_dir_down = 1'b0;
                        nxt_wrap     = 1'b1;
                    end
                end
            end
            MODE_BLINK: begin
                nxt_leds = (leds == LEDS_ZERO) ? LEDS_ONES : LEDS_ZERO;
                nxt_wrap = (leds != LEDS_ZERO);
            end
            default: begin
                nxt_leds     = start_of(mode_q);
                nxt_wrap     = 1'b0;
                nxt_dir_down = 1'b0;
            end
        endcase
    end

    // A mode change takes priority and swallows any coincident advance.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q   <= MODE_COUNT;
            leds     <= LEDS_ZERO;
            dir_down <= 1'b0;
            step     <= 1'b0;
            wrap     <= 1'b0;
        end else if (mode != mode_q) begin
            mode_q   <= mode_t'(mode);
            leds     <= start_of(mode_t'(mode));
            dir_down <= 1'b0;
            step     <= 1'b0;
            wrap     <= 1'b0;
        end else if (adv) begin
            leds     <= nxt_leds;
            dir_down <= nxt_dir_down;
            step     <= 1'b1;
            wrap     <= nxt_wrap;
        end else begin
            step     <= 1'b0;
            wrap     <= 1'b0;
        end
    end

endmodule

// File: doc/tick_led_sequencer.md
Name: tick_led_sequencer

Overview:
- Consumes the slow square wave produced by the clock divider and steps an LED pattern once per tick edge.
- Synchronises the tick, detects its edges, and runs a mode-selectable pattern engine: binary count, walking one, bounce, or blink.
- Drives the board LEDs directly.
- Emits step and wrap strobes for downstream status logic.

Parameters:
- LED_COUNT, 5, number of LED outputs; legal range 2..16.
- SYNC_STAGES, 2, synchroniser depth on tick_in; legal minimum 2.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous, active-low reset.
- tick_in  input  1  divider toggle output; treated as asynchronous.
- en  input  1  advance enable; tick edges seen while en=0 are discarded, not queued.
- mode  input  2  pattern select: 0 COUNT, 1 WALK, 2 BOUNCE, 3 BLINK.
- leds  output  LED_COUNT  current pattern, registered.
- step  output  1  one-cycle pulse on every pattern advance.
- wrap  output  1  one-cycle pulse when the pattern returns to its start state.

Behaviour:
- Reset (RST_N=0, asynchronous, takes effect immediately, also mid-operation) clears:
  - all synchroniser flops and the tick_d delay flop;
  - mode_q to 0, leds to 0, dir to up, step to 0, wrap to 0.
  - After release, the first CLK edge begins normal operation.
- Synchroniser and edge detect:
  - tick_in passes through SYNC_STAGES flops to give tick_s; tick_d holds tick_s delayed one cycle.
  - adv = tick_s & ~tick_d & en.
- Latency: leds update and step=1 on the (SYNC_STAGES+1)th CLK edge after the first edge that samples tick_in=1. This is 3 edges at the default depth.
- Mode change:
  - mode is compared to mode_q every cycle.
  - On mismatch, the next edge loads mode_q and forces the start state of the new mode; dir is set to up.
  - step and wrap stay 0 on that edge.
  - A simultaneous adv is discarded; mode change wins.
- Patterns (start state in brackets):
  - COUNT [0]: leds increments modulo 2^LED_COUNT. wrap on the transition from all-ones to 0.
  - WALK [bit0 only]: one-hot rotates left; bit LED_COUNT-1 goes to bit0. wrap when bit0 becomes set again.
  - BOUNCE [bit0, dir up]:
    - One-hot moves up while dir=up and down while dir=down.
    - On reaching bit LED_COUNT-1, dir becomes down; on reaching bit0, dir becomes up. dir is updated on the same edge.
    - Period is 2*LED_COUNT-2 steps. wrap on arrival at bit0.
  - BLINK [0]: leds alternates between all-ones and 0. wrap on return to 0.
- step equals the registered adv: high for exactly one cycle, on the same edge that leds change.
- wrap is high only on an edge where step is also high.
- If mode_q holds an out-of-range state (e.g. after an upset), the next adv loads the start state of mode_q and does not pulse wrap.
- When en=0, leds, dir, step=0 and wrap=0 hold. Re-asserting en does not replay missed edges.
- A tick_in pulse shorter than one CLK period may be missed; the divider output is always far slower than CLK.

Optional Feature:
- Macro: SEQ_DUAL_EDGE_EN.
- Defined: adv = (tick_s ^ tick_d) & en. Both rising and falling tick edges advance, doubling the step rate for the same divider setting. Latency is the same for both edge types.
- Undefined: rising edges only, as above. The falling edge has no effect.

Test Plan (LED_COUNT=5, SYNC_STAGES=2, macro undefined unless stated):
- Reset then 3 tick_in rising edges in COUNT mode -> leds 1, 2, 3. Each change lands exactly 3 CLK edges after tick_in is first sampled high; one step pulse per change; wrap=0.
- WALK, 5 ticks from reset state -> leds 00010, 00100, 01000, 10000, 00001. wrap pulses only on the 5th tick, together with step.
- BOUNCE, 8 ticks -> 00010, 00100, 01000, 10000, 01000, 00100, 00010, 00001. wrap pulses on the 8th tick only.
- COUNT with leds=31, one tick -> leds=0, step=1, wrap=1. Then en=0 and 4 ticks -> leds hold 0, no step. en=1 and 1 tick -> leds=1.
- WALK at leds=00100; set mode=3 on the same cycle that adv is asserted -> next edge leds=0, step=0, wrap=0. Following tick -> leds=11111. Assert RST_N=0 between CLK edges -> leds=0 immediately.
- With SEQ_DUAL_EDGE_EN in COUNT, one full tick_in period (rise then fall) -> leds=2, two step pulses, each 3 CLK edges after its respective tick edge is first sampled.
